// File: rtl/cache_arbiter_pkg.sv
// Shared LC-3b memory-side types and constants used by the cache arbiter.
package lc3b_types;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_datbus;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_BUSY = 2'd1,
        D_BUSY = 2'd2,
        DONE   = 2'd3
    } arb_state_t;

    localparam int ARB_STARVE_CNT_MAX = 15;
    localparam int ARB_PERF_WIDTH     = 16;

    // Increment that sticks at the starvation ceiling instead of wrapping.
    function automatic logic [3:0] sat_inc4(input logic [3:0] value);
        return (value == 4'(ARB_STARVE_CNT_MAX)) ? value : value + 4'd1;
    endfunction

endpackage

// File: rtl/cache_arbiter_starve_ctr.sv
// Saturating 4-bit count of D grants made while the I-side was kept waiting.
module arb_starve_ctr
    import lc3b_types::*;
#(
    parameter int LIMIT = 4
)(
    input  logic clk,
    input  logic rst,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_ge_limit
);

    logic [3:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc) begin
            r_cnt <= sat_inc4(r_cnt);
        end
    end

    assign o_ge_limit = (r_cnt >= 4'(LIMIT));

endmodule

// File: rtl/cache_arbiter.sv
// Shares one pmem line port between the I-cache and D-cache miss paths; D has priority with an I anti-starvation override.
// Define ARB_PERF_CNT_EN to build the grant/wait performance counters; otherwise the perf outputs are tied to zero.
module cache_arbiter
    import lc3b_types::*;
#(
    parameter int ADDR_WIDTH   = $bits(lc3b_word),
    parameter int LINE_WIDTH   = $bits(lc3b_datbus),
    parameter int STARVE_LIMIT = 4
)(
    input  logic                  clk,
    input  logic                  rst,

    input  logic [ADDR_WIDTH-1:0] icache_pmem_addr,
    input  logic                  icache_pmem_read,
    output logic                  icache_pmem_resp,
    output logic [LINE_WIDTH-1:0] icache_pmem_rdata,

    input  logic [ADDR_WIDTH-1:0] dcache_pmem_addr,
    input  logic                  dcache_pmem_read,
    input  logic                  dcache_pmem_write,
    input  logic [LINE_WIDTH-1:0] dcache_pmem_wdata,
    output logic                  dcache_pmem_resp,
    output logic [LINE_WIDTH-1:0] dcache_pmem_rdata,

    output logic [ADDR_WIDTH-1:0] pmem_addr,
    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic                  pmem_resp,
    input  logic [LINE_WIDTH-1:0] pmem_rdata,

    output logic [ARB_PERF_WIDTH-1:0] perf_i_grants,
    output logic [ARB_PERF_WIDTH-1:0] perf_d_grants,
    output logic [ARB_PERF_WIDTH-1:0] perf_i_wait
);

    arb_state_t r_state;
    arb_state_t w_next_state;

    logic w_i_req;
    logic w_d_req;
    logic w_force_i;
    logic w_ge_limit;
    logic w_grant_d;
    logic w_grant_i;
    logic w_busy;

    logic [ADDR_WIDTH-1:0] r_pmem_addr;
    logic [LINE_WIDTH-1:0] r_pmem_wdata;
    logic                  r_pmem_read;
    logic                  r_pmem_write;
    logic                  r_i_resp;
    logic                  r_d_resp;
    logic [LINE_WIDTH-1:0] r_i_rdata;
    logic [LINE_WIDTH-1:0] r_d_rdata;

    assign w_i_req   = icache_pmem_read;
    assign w_d_req   = dcache_pmem_read | dcache_pmem_write;
    assign w_force_i = w_i_req & w_ge_limit;
    assign w_busy    = (r_state == I_BUSY) || (r_state == D_BUSY);

    arb_starve_ctr #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve_ctr (
        .clk        (clk),
        .rst        (rst),
        .i_inc      (w_grant_d & w_i_req),
        .i_clr      (w_grant_i),
        .o_ge_limit (w_ge_limit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // DONE always returns to IDLE so a request still high during the resp cycle is not re-granted.
    always_comb begin
        w_next_state = r_state;
        w_grant_d    = 1'b0;
        w_grant_i    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_d_req && !w_force_i) begin
                    w_grant_d    = 1'b1;
                    w_next_state = D_BUSY;
                end else if (w_i_req) begin
                    w_grant_i    = 1'b1;
                    w_next_state = I_BUSY;
                end
            end
            I_BUSY, D_BUSY: begin
                if (pmem_resp) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // A D request with both read and write asserted is issued as a write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pmem_addr  <= '0;
            r_pmem_wdata <= '0;
            r_pmem_read  <= 1'b0;
            r_pmem_write <= 1'b0;
            r_i_resp     <= 1'b0;
            r_d_resp     <= 1'b0;
            r_i_rdata    <= '0;
            r_d_rdata    <= '0;
        end else begin
            r_i_resp <= 1'b0;
            r_d_resp <= 1'b0;
            if (w_grant_d) begin
                r_pmem_addr  <= dcache_pmem_addr;
                r_pmem_wdata <= dcache_pmem_wdata;
                r_pmem_write <= dcache_pmem_write;
                r_pmem_read  <= ~dcache_pmem_write;
            end else if (w_grant_i) begin
                r_pmem_addr  <= icache_pmem_addr;
                r_pmem_read  <= 1'b1;
                r_pmem_write <= 1'b0;
            end else if (w_busy && pmem_resp) begin
                r_pmem_read  <= 1'b0;
                r_pmem_write <= 1'b0;
                if (r_state == I_BUSY) begin
                    r_i_rdata <= pmem_rdata;
                    r_i_resp  <= 1'b1;
                end else begin
                    r_d_rdata <= pmem_rdata;
                    r_d_resp  <= 1'b1;
                end
            end
        end
    end

    assign pmem_addr         = r_pmem_addr;
    assign pmem_wdata        = r_pmem_wdata;
    assign pmem_read         = r_pmem_read;
    assign pmem_write        = r_pmem_write;
    assign icache_pmem_resp  = r_i_resp;
    assign icache_pmem_rdata = r_i_rdata;
    assign dcache_pmem_resp  = r_d_resp;
    assign dcache_pmem_rdata = r_d_rdata;

`ifdef ARB_PERF_CNT_EN
    logic [ARB_PERF_WIDTH-1:0] r_perf_i_grants;
    logic [ARB_PERF_WIDTH-1:0] r_perf_d_grants;
    logic [ARB_PERF_WIDTH-1:0] r_perf_i_wait;
    logic                      w_i_served;

    // The I resp flop is high exactly in the DONE cycle that follows an I transaction.
    assign w_i_served = (r_state == I_BUSY) || r_i_resp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_i_grants <= '0;
            r_perf_d_grants <= '0;
            r_perf_i_wait   <= '0;
        end else begin
            if (w_grant_i) begin
                r_perf_i_grants <= r_perf_i_grants + 1'b1;
            end
            if (w_grant_d) begin
                r_perf_d_grants <= r_perf_d_grants + 1'b1;
            end
            if (w_i_req && !w_i_served) begin
                r_perf_i_wait <= r_perf_i_wait + 1'b1;
            end
        end
    end

    assign perf_i_grants = r_perf_i_grants;
    assign perf_d_grants = r_perf_d_grants;
    assign perf_i_wait   = r_perf_i_wait;
`else
    assign perf_i_grants = '0;
    assign perf_d_grants = '0;
    assign perf_i_wait   = '0;
`endif

endmodule

// File: tb/tb_cache_arbiter.sv
// Self-checking bench for cache_arbiter: directed vector table, hand-written corner sequences, and a randomized run against a transaction-level model.
module tb_cache_arbiter;

    localparam int AW    = 16;
    localparam int LW    = 128;
    localparam int LIMIT = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] iAddr;
    logic          iRead;
    logic          iResp;
    logic [LW-1:0] iRdata;
    logic [AW-1:0] dAddr;
    logic          dRead;
    logic          dWrite;
    logic [LW-1:0] dWdata;
    logic          dResp;
    logic [LW-1:0] dRdata;
    logic [AW-1:0] pAddr;
    logic          pRead;
    logic          pWrite;
    logic [LW-1:0] pWdata;
    logic          pmemResp;
    logic [LW-1:0] pmemRdata;
    logic [15:0]   perfIGrants;
    logic [15:0]   perfDGrants;
    logic [15:0]   perfIWait;

    int compared   = 0;
    int mismatched = 0;

    cache_arbiter #(
        .ADDR_WIDTH   (AW),
        .LINE_WIDTH   (LW),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .icache_pmem_addr  (iAddr),
        .icache_pmem_read  (iRead),
        .icache_pmem_resp  (iResp),
        .icache_pmem_rdata (iRdata),
        .dcache_pmem_addr  (dAddr),
        .dcache_pmem_read  (dRead),
        .dcache_pmem_write (dWrite),
        .dcache_pmem_wdata (dWdata),
        .dcache_pmem_resp  (dResp),
        .dcache_pmem_rdata (dRdata),
        .pmem_addr         (pAddr),
        .pmem_read         (pRead),
        .pmem_write        (pWrite),
        .pmem_wdata        (pWdata),
        .pmem_resp         (pmemResp),
        .pmem_rdata        (pmemRdata),
        .perf_i_grants     (perfIGrants),
        .perf_d_grants     (perfDGrants),
        .perf_i_wait       (perfIWait)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          iRd;
        logic          dRd;
        logic          dWr;
        logic [AW-1:0] iA;
        logic [AW-1:0] dA;
        logic [LW-1:0] wd;
        int            delay;
        logic [LW-1:0] rd;
        bit            expD;
        logic          expWrite;
        logic [AW-1:0] expAddr;
    } vec_t;

    task automatic checkOutput(input string name, input logic [LW-1:0] actual, input logic [LW-1:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic doReset();
        rst = 1'b1;
        iRead = 1'b0; iAddr = '0;
        dRead = 1'b0; dWrite = 1'b0; dAddr = '0; dWdata = '0;
        pmemResp = 1'b0; pmemRdata = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic waitOp(input int budget, output int lat);
        lat = 0;
        while (!(pRead || pWrite) && lat < budget) begin
            tick();
            lat++;
        end
        if (!(pRead || pWrite)) checkOutput("op_timeout", LW'(pRead | pWrite), LW'(1));
    endtask

    // Drives one vector, serves the winning side with the vector's pmem delay, then releases all requests.
    task automatic applyStimulus(input vec_t v);
        int lat;
        iRead = v.iRd; iAddr = v.iA;
        dRead = v.dRd; dWrite = v.dWr; dAddr = v.dA; dWdata = v.wd;
        waitOp(6, lat);
        checkOutput("grant_latency", LW'(lat), LW'(1));
        checkOutput("pmem_write", LW'(pWrite), LW'(v.expWrite));
        checkOutput("pmem_read", LW'(pRead), LW'(!v.expWrite));
        checkOutput("pmem_addr", LW'(pAddr), LW'(v.expAddr));
        if (v.expWrite) checkOutput("pmem_wdata", pWdata, v.wd);
        for (int k = 0; k < v.delay; k++) begin
            tick();
            checkOutput("hold_op", LW'(pRead | pWrite), LW'(1));
            checkOutput("early_resp", LW'(iResp | dResp), LW'(0));
        end
        pmemResp = 1'b1; pmemRdata = v.rd;
        tick();
        pmemResp = 1'b0;
        if (v.expD) begin
            checkOutput("d_resp", LW'(dResp), LW'(1));
            checkOutput("d_rdata", dRdata, v.rd);
            checkOutput("i_resp_quiet", LW'(iResp), LW'(0));
        end else begin
            checkOutput("i_resp", LW'(iResp), LW'(1));
            checkOutput("i_rdata", iRdata, v.rd);
            checkOutput("d_resp_quiet", LW'(dResp), LW'(0));
        end
        checkOutput("op_cleared", LW'(pRead | pWrite), LW'(0));
        iRead = 1'b0; dRead = 1'b0; dWrite = 1'b0;
        tick();
        checkOutput("resp_one_cycle", LW'(iResp | dResp), LW'(0));
    endtask

    // Transaction-level reference state for the randomized run.
    int            mOwner;
    bit            mCompleting;
    int            mStreak;
    logic [AW-1:0] mAddr;
    logic [LW-1:0] mWdata;
    bit            mRd, mWr, mIResp, mDResp;
    logic [LW-1:0] mIRdata, mDRdata;
    logic [15:0]   mPerfI, mPerfD, mPerfW;

    initial begin
        vec_t  table_v[7];
        vec_t  v;
        int    lat;
        int    side;
        int    expSeq[6];
        bit    iPend, dPend;
        int    pmemDelay;
        bit    iReq, dReq, nIResp, nDResp;
        logic [15:0] eI, eD, eW;

        table_v[0] = '{1'b1, 1'b0, 1'b0, 16'h1230, 16'h0000, '0, 3, {4{32'h1111_2222}}, 1'b0, 1'b0, 16'h1230};
        table_v[1] = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h2000, '0, 0, {4{32'h3333_4444}}, 1'b1, 1'b0, 16'h2000};
        table_v[2] = '{1'b1, 1'b0, 1'b1, 16'h1110, 16'h4000, {16{8'hA5}}, 1, {4{32'h5555_6666}}, 1'b1, 1'b1, 16'h4000};
        table_v[3] = '{1'b1, 1'b0, 1'b0, 16'h0FF0, 16'h0000, '0, 2, {4{32'h7777_8888}}, 1'b0, 1'b0, 16'h0FF0};
        table_v[4] = '{1'b0, 1'b1, 1'b1, 16'h0000, 16'h3330, {16{8'h5A}}, 2, {4{32'h9999_AAAA}}, 1'b1, 1'b1, 16'h3330};
        table_v[5] = '{1'b1, 1'b1, 1'b0, 16'h7770, 16'h8880, '0, 0, {4{32'hBBBB_CCCC}}, 1'b1, 1'b0, 16'h8880};
        table_v[6] = '{1'b1, 1'b0, 1'b0, 16'hFFF0, 16'h0000, '0, 5, {4{32'hDDDD_EEEE}}, 1'b0, 1'b0, 16'hFFF0};

        // Reset state, checked while reset is held.
        rst = 1'b1;
        iRead = 1'b0; iAddr = '0; dRead = 1'b0; dWrite = 1'b0; dAddr = '0; dWdata = '0;
        pmemResp = 1'b0; pmemRdata = '0;
        #1;
        checkOutput("rst_pmem_rw", LW'({pRead, pWrite}), LW'(0));
        checkOutput("rst_pmem_addr", LW'(pAddr), LW'(0));
        checkOutput("rst_pmem_wdata", pWdata, LW'(0));
        checkOutput("rst_resps", LW'({iResp, dResp}), LW'(0));
        checkOutput("rst_i_rdata", iRdata, LW'(0));
        checkOutput("rst_d_rdata", dRdata, LW'(0));
        checkOutput("rst_perf", LW'({perfIGrants, perfDGrants, perfIWait}), LW'(0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int n = 0; n < 7; n++) applyStimulus(table_v[n]);

        // Simultaneous I read and D write: D first, I served right after D's DONE cycle.
        doReset();
        iRead = 1'b1; iAddr = 16'h1230;
        dWrite = 1'b1; dAddr = 16'h4000; dWdata = {16{8'hA5}};
        waitOp(6, lat);
        checkOutput("both_d_first_write", LW'(pWrite), LW'(1));
        checkOutput("both_d_wdata", pWdata, {16{8'hA5}});
        checkOutput("both_d_addr", LW'(pAddr), LW'(16'h4000));
        pmemResp = 1'b1; pmemRdata = {4{32'hCAFE_F00D}};
        tick();
        pmemResp = 1'b0;
        checkOutput("both_d_resp", LW'(dResp), LW'(1));
        dWrite = 1'b0;
        tick();
        checkOutput("both_idle_gap", LW'(pRead | pWrite), LW'(0));
        tick();
        checkOutput("both_i_second", LW'(pRead), LW'(1));
        checkOutput("both_i_addr", LW'(pAddr), LW'(16'h1230));
        pmemResp = 1'b1; pmemRdata = {4{32'h0BAD_BEEF}};
        tick();
        pmemResp = 1'b0;
        checkOutput("both_i_resp", LW'(iResp), LW'(1));
        checkOutput("both_i_rdata", iRdata, {4{32'h0BAD_BEEF}});
        checkOutput("both_d_rdata_kept", dRdata, {4{32'hCAFE_F00D}});
        iRead = 1'b0;
        tick();

        // D re-requests continuously while I waits: four D grants, then a forced I, then D again.
        doReset();
        expSeq = '{2, 2, 2, 2, 1, 2};
        iRead = 1'b1; iAddr = 16'hA000;
        dRead = 1'b1; dAddr = 16'hB000;
        for (int g = 0; g < 6; g++) begin
            waitOp(6, lat);
            side = (pAddr == 16'hA000) ? 1 : 2;
            checkOutput("starve_grant_order", LW'(side), LW'(expSeq[g]));
            pmemResp = 1'b1;
            tick();
            pmemResp = 1'b0;
            if (side == 2) dRead = 1'b0; else iRead = 1'b0;
            tick();
            if (side == 2) dRead = 1'b1; else iRead = 1'b1;
        end
        iRead = 1'b0; dRead = 1'b0;
        tick(); tick(); tick(); tick();

        // Spurious pmem_resp while idle, then a requester that holds its read through DONE.
        doReset();
        pmemResp = 1'b1; pmemRdata = {4{32'hDEAD_0001}};
        tick();
        pmemResp = 1'b0;
        checkOutput("spurious_no_resp", LW'(iResp | dResp), LW'(0));
        checkOutput("spurious_rdata", iRdata | dRdata, LW'(0));
        iRead = 1'b1; iAddr = 16'h5550;
        waitOp(6, lat);
        pmemResp = 1'b1; pmemRdata = {4{32'h1234_5678}};
        tick();
        pmemResp = 1'b0;
        checkOutput("hold_done_resp", LW'(iResp), LW'(1));
        tick();
        checkOutput("no_regrant_from_done", LW'(pRead), LW'(0));
        checkOutput("hold_single_resp", LW'(iResp), LW'(0));
        iRead = 1'b0;
        tick();
        checkOutput("no_regrant_idle", LW'(pRead), LW'(0));

        // Reset in the middle of a D write abandons it without a response.
        dWrite = 1'b1; dAddr = 16'h4000; dWdata = {16{8'hA5}};
        waitOp(6, lat);
        tick();
        #2 rst = 1'b1;
        #1;
        checkOutput("midrst_write_drop", LW'(pWrite), LW'(0));
        checkOutput("midrst_no_resp", LW'(dResp), LW'(0));
        dWrite = 1'b0;
        @(negedge clk);
        pmemResp = 1'b1;
        tick();
        pmemResp = 1'b0;
        checkOutput("midrst_still_no_resp", LW'(dResp), LW'(0));
        rst = 1'b0;
        applyStimulus(table_v[0]);

        // Three I and two D sequential transactions for the performance counters.
        doReset();
        for (int n = 0; n < 5; n++) begin
            v = (n < 3) ? table_v[3] : table_v[1];
            applyStimulus(v);
        end
`ifdef ARB_PERF_CNT_EN
        checkOutput("perf_i_grants", LW'(perfIGrants), LW'(3));
        checkOutput("perf_d_grants", LW'(perfDGrants), LW'(2));
        checkOutput("perf_i_wait", LW'(perfIWait), LW'(3));
`else
        checkOutput("perf_i_grants_off", LW'(perfIGrants), LW'(0));
        checkOutput("perf_d_grants_off", LW'(perfDGrants), LW'(0));
        checkOutput("perf_i_wait_off", LW'(perfIWait), LW'(0));
`endif

        // Randomized traffic against the reference model.
        doReset();
        mOwner = 0; mCompleting = 1'b0; mStreak = 0;
        mAddr = '0; mWdata = '0; mRd = 1'b0; mWr = 1'b0; mIResp = 1'b0; mDResp = 1'b0;
        mIRdata = '0; mDRdata = '0; mPerfI = '0; mPerfD = '0; mPerfW = '0;
        iPend = 1'b0; dPend = 1'b0; pmemDelay = $urandom_range(3);
        for (int cyc = 0; cyc < 3000; cyc++) begin
`ifdef ARB_PERF_CNT_EN
            eI = mPerfI; eD = mPerfD; eW = mPerfW;
`else
            eI = '0; eD = '0; eW = '0;
`endif
            checkOutput("rnd_pmem_read", LW'(pRead), LW'(mRd));
            checkOutput("rnd_pmem_write", LW'(pWrite), LW'(mWr));
            if (mOwner != 0) checkOutput("rnd_pmem_addr", LW'(pAddr), LW'(mAddr));
            if (mWr) checkOutput("rnd_pmem_wdata", pWdata, mWdata);
            checkOutput("rnd_i_resp", LW'(iResp), LW'(mIResp));
            checkOutput("rnd_d_resp", LW'(dResp), LW'(mDResp));
            checkOutput("rnd_i_rdata", iRdata, mIRdata);
            checkOutput("rnd_d_rdata", dRdata, mDRdata);
            checkOutput("rnd_perf", LW'({perfIGrants, perfDGrants, perfIWait}), LW'({eI, eD, eW}));

            if (mIResp) begin
                iRead = 1'b0; iPend = 1'b0;
            end else if (!iPend && $urandom_range(3) == 0) begin
                iPend = 1'b1; iRead = 1'b1; iAddr = AW'($urandom);
            end else if (mOwner == 1) begin
                iAddr = AW'($urandom);
            end
            if (mDResp) begin
                dRead = 1'b0; dWrite = 1'b0; dPend = 1'b0;
            end else if (!dPend && $urandom_range(2) == 0) begin
                dPend = 1'b1;
                case ($urandom_range(5))
                    0, 1, 2: begin dRead = 1'b1; dWrite = 1'b0; end
                    3, 4:    begin dRead = 1'b0; dWrite = 1'b1; end
                    default: begin dRead = 1'b1; dWrite = 1'b1; end
                endcase
                dAddr = AW'($urandom);
                dWdata = {$urandom, $urandom, $urandom, $urandom};
            end else if (mOwner == 2) begin
                dAddr = AW'($urandom);
                dWdata = {$urandom, $urandom, $urandom, $urandom};
            end
            if (mRd || mWr) begin
                if (pmemDelay == 0) begin
                    pmemResp = 1'b1;
                    pmemRdata = {$urandom, $urandom, $urandom, $urandom};
                    pmemDelay = $urandom_range(4);
                end else begin
                    pmemResp = 1'b0;
                    pmemDelay--;
                end
            end else begin
                pmemResp = ($urandom_range(7) == 0);
                pmemRdata = {$urandom, $urandom, $urandom, $urandom};
            end

            // Predict the effect of the coming clock edge.
            iReq = iRead;
            dReq = dRead | dWrite;
            nIResp = 1'b0;
            nDResp = 1'b0;
            if (iReq && !(mOwner == 1 || mIResp)) mPerfW++;
            if (mCompleting) begin
                mCompleting = 1'b0;
            end else if (mOwner != 0) begin
                if (pmemResp) begin
                    if (mOwner == 1) begin mIRdata = pmemRdata; nIResp = 1'b1; end
                    else begin mDRdata = pmemRdata; nDResp = 1'b1; end
                    mRd = 1'b0; mWr = 1'b0; mOwner = 0; mCompleting = 1'b1;
                end
            end else if (dReq && !(iReq && mStreak >= LIMIT)) begin
                mOwner = 2; mAddr = dAddr; mWdata = dWdata;
                mWr = dWrite; mRd = !dWrite; mPerfD++;
                if (iReq) mStreak = (mStreak < 15) ? mStreak + 1 : 15;
            end else if (iReq) begin
                mOwner = 1; mAddr = iAddr; mRd = 1'b1; mWr = 1'b0;
                mStreak = 0; mPerfI++;
            end
            mIResp = nIResp;
            mDResp = nDResp;
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/cache_arbiter.md
Name: cache_arbiter

Overview:
- Shares one physical-memory (L2/pmem) line port between the I-cache miss path and the D-cache miss/writeback path.
- Sits below the L1 caches that feed cpu_datapath.
- Serves one whole-line transaction at a time.
- D-side has priority. A starvation counter forces an I grant after STARVE_LIMIT consecutive D grants while I waits.
- Downstream request and upstream response signals are registered.

Parameters:
ADDR_WIDTH, 16, byte address width (lc3b_word)
LINE_WIDTH, 128, cache line width (lc3b_datbus)
STARVE_LIMIT, 4, max consecutive D grants while I pending before I is forced; legal range 1..15

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
icache_pmem_addr  in  ADDR_WIDTH  I-side line address
icache_pmem_read  in  1  I-side read request, held until icache_pmem_resp
icache_pmem_resp  out  1  one-cycle completion pulse to I-side
icache_pmem_rdata  out  LINE_WIDTH  line returned to I-side, valid with resp
dcache_pmem_addr  in  ADDR_WIDTH  D-side line address
dcache_pmem_read  in  1  D-side read request
dcache_pmem_write  in  1  D-side write request
dcache_pmem_wdata  in  LINE_WIDTH  D-side write line
dcache_pmem_resp  out  1  one-cycle completion pulse to D-side
dcache_pmem_rdata  out  LINE_WIDTH  line returned to D-side, valid with resp
pmem_addr  out  ADDR_WIDTH  downstream address
pmem_read  out  1  downstream read, held until pmem_resp
pmem_write  out  1  downstream write, held until pmem_resp
pmem_wdata  out  LINE_WIDTH  downstream write line
pmem_resp  in  1  downstream completion
pmem_rdata  in  LINE_WIDTH  downstream read line, valid with pmem_resp

Behaviour:
- Reset (async):
  - state=IDLE, starve_cnt=0.
  - All outputs 0, including pmem_addr/wdata and both rdata buses.
- States: IDLE, I_BUSY, D_BUSY, DONE.
- IDLE arbitration:
  - d_req = dcache_pmem_read|dcache_pmem_write; i_req = icache_pmem_read.
  - Grant D if d_req && !(i_req && starve_cnt>=STARVE_LIMIT); else grant I if i_req; else stay in IDLE.
- On grant (registered at the edge):
  - Capture addr/wdata into pmem_addr/pmem_wdata.
  - Set pmem_read or pmem_write.
  - Enter I_BUSY or D_BUSY.
  - If D has both read and write asserted, write wins (illegal input, defined behaviour).
- Starvation counter:
  - D granted while i_req: starve_cnt+1, saturating at 15.
  - I granted: starve_cnt=0.
  - Otherwise unchanged.
- BUSY:
  - pmem_read/write and pmem_addr/wdata are held stable; upstream input changes are ignored.
  - On pmem_resp: clear pmem_read/write, copy pmem_rdata into the granted side's rdata, pulse that side's resp for exactly one cycle, enter DONE.
  - A pmem_resp seen in IDLE or DONE is ignored.
- DONE:
  - Resp is high this cycle; the requester drops its request by the next edge.
  - Next state is IDLE unconditionally, so a stale request is never re-granted.
  - Non-granted rdata keeps its previous value.
- Latency: request seen in IDLE at cycle 0 → pmem_read/write high at cycle 1. pmem_resp at cycle k → requester resp at cycle k+1. Zero-wait pmem gives 2-cycle latency.
- Throughput: at most one grant every 3 cycles (IDLE→BUSY→DONE minimum).
- Reset mid-transaction: the pmem transaction is abandoned and pmem_read/write drop immediately. No resp is issued. pmem must tolerate the dropped request.

Optional Feature:
ARB_PERF_CNT_EN:
- Defined: three 16-bit wrap-around counters, cleared by rst, exposed on extra outputs perf_i_grants, perf_d_grants, perf_i_wait.
  - perf_i_grants and perf_d_grants increment per grant.
  - perf_i_wait increments every cycle i_req is high and I is not in I_BUSY/DONE.
- Undefined: the same three output ports exist, tied to 0, and no counter flops are synthesized.

Decomposition:
- Shared package lc3b_types:
  - enum arb_state_t {IDLE, I_BUSY, D_BUSY, DONE}.
  - Reuse lc3b_word and lc3b_datbus for the default widths.
  - Constant ARB_STARVE_CNT_MAX=15.
- One sub-module: arb_starve_ctr, the saturating 4-bit counter with inc/clr inputs and a ge_limit output.

Test Plan:
- I-only read to 0x1230, pmem_resp 3 cycles after pmem_read → pmem_addr=0x1230 at cycle 1; icache_pmem_resp pulses 1 cycle with pmem_rdata; then IDLE.
- I read and D write (addr 0x4000, wdata 0xA5..A5) raised in the same cycle → D granted first: pmem_write=1, pmem_wdata=0xA5..A5. I granted after D's DONE cycle.
- D requests continuously while I waits, STARVE_LIMIT=4 → grants D,D,D,D,I; starve_cnt returns to 0 after the I grant.
- pmem_resp pulsed while IDLE, and the requester holding req through DONE → no spurious resp, and no re-grant from DONE.
- rst asserted mid-D_BUSY → pmem_write=0 asynchronously, no dcache_pmem_resp; after release, a new I read is served normally.
- With ARB_PERF_CNT_EN, 3 I grants and 2 D grants → perf_i_grants=3, perf_d_grants=2. Without the macro, all perf outputs read 0.
